fetch_stage: RTL

//  Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of decode and the

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache reads, and holds the IF/ID register.
// A one-entry skid buffer keeps a word that returns while decode is stalled.
module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        pcEN,
    input  logic        fdEN,
    input  logic        fd_flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] instr_out,
    output logic [31:0] pcplus4_out,
    output logic        valid_out
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t            r_state,      w_state_nxt;
    logic [XLEN-1:0]   r_pc,         w_pc_nxt;
    logic [XLEN-1:0]   r_skid_instr, w_skid_instr_nxt;
    logic [XLEN-1:0]   r_skid_pc4,   w_skid_pc4_nxt;
    logic [XLEN-1:0]   r_instr,      w_instr_nxt;
    logic [XLEN-1:0]   r_pc4,        w_pc4_nxt;
    logic              r_valid,      w_valid_nxt;
    logic [XLEN-1:0]   w_pc_plus4;
    logic              w_accept;

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_accept   = ihit & pcEN;

    assign imemaddr    = r_pc;
    assign imemREN     = (r_state == S_FETCH);
    assign instr_out   = r_instr;
    assign pcplus4_out = r_pc4;
    assign valid_out   = r_valid;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state      <= S_FETCH;
            r_pc         <= PC_INIT & ALIGN_MASK;
            r_skid_instr <= '0;
            r_skid_pc4   <= '0;
            r_instr      <= NOP_INSTR;
            r_pc4        <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc4   <= w_skid_pc4_nxt;
            r_instr      <= w_instr_nxt;
            r_pc4        <= w_pc4_nxt;
            r_valid      <= w_valid_nxt;
        end
    end

    // Priority: halted/halt freezes everything, then redirect, then per-state fetch actions.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc4_nxt   = r_skid_pc4;
        w_instr_nxt      = r_instr;
        w_pc4_nxt        = r_pc4;
        w_valid_nxt      = r_valid;

        if (r_state == S_HALTED) begin
            w_state_nxt = S_HALTED;
        end else if (halt) begin
            w_state_nxt = S_HALTED;
        end else begin
            if (redirect) begin
                // Skid is emptied by leaving HOLD; its contents are never delivered.
                w_pc_nxt    = redirect_pc & ALIGN_MASK;
                w_state_nxt = S_FETCH;
            end else begin
                case (r_state)
                    S_FETCH: begin
                        if (w_accept) begin
                            w_pc_nxt = w_pc_plus4;
                            if (fdEN) begin
                                w_instr_nxt = iload;
                                w_pc4_nxt   = w_pc_plus4;
                                w_valid_nxt = 1'b1;
                            end else begin
                                w_skid_instr_nxt = iload;
                                w_skid_pc4_nxt   = w_pc_plus4;
                                w_state_nxt      = S_HOLD;
                            end
                        end else if (fdEN) begin
                            w_instr_nxt = NOP_INSTR;
                            w_valid_nxt = 1'b0;
                        end
                    end
                    S_HOLD: begin
                        if (fdEN) begin
                            w_instr_nxt = r_skid_instr;
                            w_pc4_nxt   = r_skid_pc4;
                            w_valid_nxt = 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                    end
                    default: w_state_nxt = r_state;
                endcase
            end

            if (fd_flush) begin
                w_instr_nxt = NOP_INSTR;
                w_pc4_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        end
    end

endmodule
